// File: rtl/onehot_decode_seq.sv
// onehot_decode_seq
//   Sequenced one-hot decoder. A request either decodes one opcode onto led
//   for HOLD_CYCLES cycles (mode=0), or walks every legal opcode in ascending
//   order, each for HOLD_CYCLES cycles (mode=1). Opcodes whose VALID_MASK bit
//   is clear are rejected with a one-cycle illegal pulse (single decode) or
//   skipped without cost (scan).
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   sel        opcode to decode (SEL_W)
//   in_valid   request present; accepted when in_ready is also high
//   mode       0 = single decode, 1 = scan all legal codes
//   clr        synchronous abort back to IDLE
//   in_ready   block idle (decoded from state only)
//   led        registered one-hot code, zero when out_valid is low
//   out_valid  led carries a code
//   illegal    one-cycle pulse on a rejected request
module onehot_decode_seq #(
  parameter int               SEL_W       = 2,
  parameter int               OUT_W       = 2**SEL_W,
  parameter int               HOLD_CYCLES = 4,
  parameter logic [OUT_W-1:0] VALID_MASK  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             clr,
  output logic             in_ready,
  output logic [OUT_W-1:0] led,
  output logic             out_valid,
  output logic             illegal
);

  localparam int             CW     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SEL_W-1:0] idx;        // code currently shown during a scan

  logic [SEL_W-1:0] first_idx;  // lowest legal code
  logic             first_ok;   // at least one legal code exists
  logic [SEL_W-1:0] next_idx;   // lowest legal code above idx
  logic             next_ok;

  // Descending loops: the last hit is the lowest matching index, so illegal
  // codes are skipped in zero cycles.
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    next_idx  = '0;
    next_ok   = 1'b0;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      if (VALID_MASK[i]) begin
        first_idx = SEL_W'(i);
        first_ok  = 1'b1;
        if (i > int'(idx)) begin
          next_idx = SEL_W'(i);
          next_ok  = 1'b1;
        end
      end
    end
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      led       <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (clr) begin
        // Abort wins over everything, including a request arriving in IDLE.
        state     <= IDLE;
        cnt       <= '0;
        led       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              if (mode) begin
                if (first_ok) begin
                  state     <= SCAN;
                  idx       <= first_idx;
                  led       <= OUT_W'(1) << first_idx;
                  out_valid <= 1'b1;
                  cnt       <= RELOAD;
                end else begin
                  illegal <= 1'b1;
                end
              end else if (VALID_MASK[sel]) begin
                state     <= HOLD;
                led       <= OUT_W'(1) << sel;
                out_valid <= 1'b1;
                cnt       <= RELOAD;
              end else begin
                illegal <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (cnt == '0) begin
              state     <= IDLE;
              led       <= '0;
              out_valid <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SCAN: begin
            if (cnt == '0) begin
              if (next_ok) begin
                idx <= next_idx;
                led <= OUT_W'(1) << next_idx;
                cnt <= RELOAD;
              end else begin
                // Single pass: no wrap after the highest legal code.
                state     <= IDLE;
                led       <= '0;
                out_valid <= 1'b0;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            led       <= '0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onehot_decode_seq.sv
// Directed bench for onehot_decode_seq with SEL_W=2, HOLD_CYCLES=3,
// VALID_MASK=4'b1011 (opcode 2 illegal). Inputs change 1ns after a rising
// edge; outputs are sampled at that same point.
module tb_onehot_decode_seq;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic       in_valid;
  logic       mode;
  logic       clr;
  logic       in_ready;
  logic [3:0] led;
  logic       out_valid;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;

  onehot_decode_seq #(
    .SEL_W(2), .OUT_W(4), .HOLD_CYCLES(3), .VALID_MASK(4'b1011)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .mode(mode),
    .clr(clr), .in_ready(in_ready), .led(led), .out_valid(out_valid),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full output set against expectations.
  task automatic chk(input string name, input logic [3:0] e_led,
                     input logic e_ov, input logic e_rdy, input logic e_ill);
    n_cmp++;
    if ({led, out_valid, in_ready, illegal} !== {e_led, e_ov, e_rdy, e_ill}) begin
      n_err++;
      $display("FAIL %s: got led=%b ov=%b rdy=%b ill=%b, want led=%b ov=%b rdy=%b ill=%b",
               name, led, out_valid, in_ready, illegal, e_led, e_ov, e_rdy, e_ill);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = '0; in_valid = 1'b0; mode = 1'b0; clr = 1'b0;
    #3;
    chk("reset_state", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    chk("after_release", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_single_legal();
    sel = 2'b01; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s1_hold%0d", i), 4'b0010, 1'b1, 1'b0, 1'b0);
      // busy: sel/mode changes must be ignored
      sel = 2'b11; mode = 1'b1;
      tick();
    end
    chk("s1_done", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_single_illegal();
    sel = 2'b10; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s2_pulse", 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("s2_pulse_end", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_scan();
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0001, 4'b0001,
                                4'b0010, 4'b0010, 4'b0010,
                                4'b1000, 4'b1000, 4'b1000};
    sel = 2'b10; mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mode = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("s3_scan%0d", i), exp_seq[i], 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("s3_done", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk("s3_no_wrap", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clr_scan();
    mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mode = 1'b0;
    chk("s4_scan_c1", 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    chk("s4_scan_c2", 4'b0001, 1'b1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("s4_cleared", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk("s4_stays_idle", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_rst_mid_hold();
    sel = 2'b01; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("s5_hold", 4'b0010, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("s5_async_rst", 4'b0000, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b0;
    tick();
    chk("s5_no_resume", 4'b0000, 1'b0, 1'b1, 1'b0);
    sel = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s5_hold3_%0d", i), 4'b1000, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("s5_done", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clr_with_req();
    sel = 2'b01; mode = 1'b0; in_valid = 1'b1; clr = 1'b1;
    tick();
    chk("s6_clr_wins", 4'b0000, 1'b0, 1'b1, 1'b0);
    sel = 2'b10;
    tick();
    in_valid = 1'b0; clr = 1'b0;
    chk("s6_clr_illegal_req", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // New request accepted on the first IDLE cycle after a hold ends.
    sel = 2'b00; mode = 1'b0; in_valid = 1'b1;
    tick();
    sel = 2'b11;
    chk("b2b_first", 4'b0001, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("b2b_idle", 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("b2b_second", 4'b1000, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("b2b_done", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_legal();
    test_single_illegal();
    test_scan();
    test_clr_scan();
    test_rst_mid_hold();
    test_clr_with_req();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
